apb_bus_arbiter: RTL and testbench
==================================

// Module: apb_bus_arbiter
// PURPOSE
//  Shares one APB-style peripheral bus (addr 128..1023) between two masters: req0 = MIPS core, req1 = DMA/debug.
//  Round-robin arbitration; per-grant SETUP->ACCESS sequencing; one-cycle done pulse back to the winning master.
//  Sits between the core's transfer/WRITE/ADDR/WDATA outputs and the peripheral bus.
//  Drives the core's READY, ENABLE, RDATA and access_done inputs.
// PARAMETERS
//  ADDR_W       32  address width, both masters and bus
//  DATA_W       32  data width
//  TIMEOUT_CYC  16  max ACCESS cycles before abort; used only with APB_TIMEOUT_EN
// PORTS
//  CLK          in   1       clock; all logic on rising edge
//  RESETn       in   1       synchronous, active-low reset
//  req0_transfer in  1       master0 request; level, held until req0_done
//  req0_addr    in   ADDR_W  master0 address, word aligned
//  req0_write   in   1       master0 1=write, 0=read
//  req0_wdata   in   DATA_W  master0 write data
//  req0_rdata   out  DATA_W  master0 read data; valid while req0_done=1
//  req0_done    out  1       master0 completion pulse (core access_done)
//  req1_*       ---  same set as req0_*, for master1
//  gnt          out  2       one-hot current owner; 00 when idle
//  PSEL         out  1       bus select
//  PENABLE      out  1       bus access phase (core ENABLE)
//  PADDR        out  ADDR_W  bus address
//  PWRITE       out  1       bus direction
//  PWDATA       out  DATA_W  bus write data
//  PRDATA       in   DATA_W  bus read data
//  PREADY       in   1       slave ready (core READY)
//  err          out  1       one-cycle pulse with done on timeout; tied 0 without APB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (RESETn=0 at edge): all outputs 0; state=IDLE; last_gnt=1, so master0 wins the first tie.
//  Reset mid-transfer: transfer abandoned; no done pulse; PSEL/PENABLE low after that edge.
//  FSM (registered outputs):
//   IDLE:   on any reqN_transfer, pick winner, latch addr/write/wdata into PADDR/PWRITE/PWDATA,
//           set gnt, set last_gnt, go SETUP.
//   SETUP:  PSEL=1, PENABLE=0; go ACCESS unconditionally.
//   ACCESS: PSEL=1, PENABLE=1; hold until PREADY=1.
//           Then capture PRDATA (reads only) into reqN_rdata and go DONE.
//   DONE:   PSEL=0, PENABLE=0, reqN_done=1 for exactly one cycle; gnt cleared on exit; go IDLE.
//  Min latency: request seen in cycle 0 -> done=1 in cycle 3, with PREADY=1 in the first ACCESS cycle.
//  Each PREADY=0 cycle in ACCESS adds one cycle.
//  Arbitration:
//   - one requester: it wins.
//   - both requesting: the master not in last_gnt wins; strict alternation under continuous load.
//  IDLE is always visited between grants, so a master that dropped transfer on done is never re-granted stale.
//  Request withdrawn after grant: the bus transfer still completes and done still pulses.
//  PADDR/PWDATA stay stable from SETUP through ACCESS; later changes on the req inputs are ignored.
//  reqN_rdata holds its value until the next read completes for that master; writes leave it unchanged.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - a counter runs in ACCESS.
//   - after TIMEOUT_CYC cycles with PREADY=0: go DONE, pulse done and err, reqN_rdata=32'hDEAD_BEEF.
//   - counter clears on each SETUP.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err constant 0.
// STRUCTURE
//  Package apb_arb_pkg: state enum {IDLE,SETUP,ACCESS,DONE} (2 bits), ADDR_W/DATA_W defaults, TIMEOUT_RDATA constant.
//  Sub-module rr_arb2: combinational 2-way round-robin grant from {req, last_gnt}.
//  FSM, bus registers and timeout counter stay in apb_bus_arbiter.
// TESTING
//  1 Single read:
//    - stimulus: req0 addr=0x100, PREADY=1, PRDATA=0x1234_5678.
//    - response: PSEL rises c1, PENABLE c2, req0_done=1 c3, req0_rdata=0x1234_5678.
//  2 Wait states:
//    - stimulus: req1 write addr=0x200, wdata=0xA5A5_A5A5, PREADY low 3 ACCESS cycles.
//    - response: PWDATA stable throughout; req1_done in c6; req1_rdata unchanged.
//  3 Contention:
//    - stimulus: both request continuously from reset.
//    - response: gnt sequence 01,10,01,10; each done pulse one cycle; no overlapping PSEL phases.
//  4 Withdraw:
//    - stimulus: req0 drops transfer in SETUP.
//    - response: ACCESS completes, req0_done still pulses, then IDLE.
//  5 Reset mid-ACCESS:
//    - stimulus: RESETn=0 one cycle while PENABLE=1.
//    - response: next cycle PSEL=PENABLE=0, gnt=00, no done; next request is served normally.
//  6 Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4):
//    - stimulus: PREADY held 0.
//    - response: done+err pulse after 4 ACCESS cycles, rdata=0xDEAD_BEEF.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
//   Shared types and constants for the two-master APB bus arbiter.
//   - state_e       : arbiter FSM state encoding (2 bits)
//   - ADDR_W_DEF    : default address width
//   - DATA_W_DEF    : default data width
//   - TIMEOUT_RDATA : read data returned to a master whose access timed out
//                     (only used when APB_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin grant.
//   Ports:
//     req_i      [1:0] request vector, bit N = master N
//     last_gnt_i       index of the master granted most recently
//     gnt_o      [1:0] one-hot grant, 00 when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        // On a tie the master that did not win last time gets the bus.
        if (req_i == 2'b11) begin
            gnt_o = last_gnt_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// apb_bus_arbiter
//   Shares one APB peripheral bus between master0 (MIPS core) and master1
//   (DMA/debug). Round-robin grant, SETUP->ACCESS sequencing per grant and a
//   one-cycle done pulse back to the winner. All outputs are registered.
//
//   Ports:
//     CLK, RESETn              clock, synchronous active-low reset
//     reqN_transfer/addr/write/wdata   master N request (level, held to done)
//     reqN_rdata, reqN_done    master N read data / completion pulse
//     gnt                      one-hot current owner, 00 when idle
//     PSEL, PENABLE, PADDR, PWRITE, PWDATA   bus request side
//     PRDATA, PREADY           bus response side
//     err                      timeout pulse coincident with done
//
//   Configuration: APB_TIMEOUT_EN enables an ACCESS-phase watchdog that
//   aborts after TIMEOUT_CYC not-ready cycles; without it err is tied 0 and
//   ACCESS waits for PREADY indefinitely.
// ---------------------------------------------------------------------------
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              req0_transfer,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_write,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_done,
    input  logic              req1_transfer,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_write,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_done,
    output logic [1:0]        gnt,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              err
);

    state_e                  state_q, state_d;
    logic [1:0]              gnt_q, gnt_d;
    logic                    last_q, last_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic [1:0]              done_q, done_d;
    logic [1:0]              arb_gnt;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
`endif

    rr_arb2 u_arb (
        .req_i      ({req1_transfer, req0_transfer}),
        .last_gnt_i (last_q),
        .gnt_o      (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        done_d    = 2'b00;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    // Request fields are captured once here; the bus never
                    // looks at the req inputs again for this grant.
                    paddr_d  = arb_gnt[1] ? req1_addr  : req0_addr;
                    pwrite_d = arb_gnt[1] ? req1_write : req0_write;
                    pwdata_d = arb_gnt[1] ? req1_wdata : req0_wdata;
                    gnt_d    = arb_gnt;
                    last_d   = arb_gnt[1];
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = gnt_q;
                    if (!pwrite_q) begin
                        rdata_d[gnt_q[1]] = PRDATA;
                    end
                    state_d   = DONE;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    done_d            = gnt_q;
                    err_d             = 1'b1;
                    rdata_d[gnt_q[1]] = DATA_W'(TIMEOUT_RDATA);
                    state_d           = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                // Always pass through IDLE so a master that dropped its
                // request on done is never granted again on stale inputs.
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 2'b00;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PADDR      = paddr_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
`ifdef APB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_bus_arbiter
//   Scoreboard bench for apb_bus_arbiter: each transfer pushes its expected
//   completion (master, rdata, err); a negedge monitor pops on every done
//   pulse. Directed cycle checks cover latency, bus sequencing, arbitration,
//   withdraw and reset. Define APB_TIMEOUT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_apb_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        req0_transfer, req0_write, req1_transfer, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_done, req1_done;
    logic [1:0]  gnt;
    logic        PSEL, PENABLE, PWRITE, PREADY, err;
    logic [31:0] PADDR, PWDATA, PRDATA;

    logic        use_mem;
    logic [31:0] prdata_drv;

    // Simple slave: either a fixed word or an address-derived pattern.
    assign PRDATA = use_mem ? {16'h5A00, PADDR[15:0]} : prdata_drv;

    always #5 CLK = ~CLK;

    apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req0_transfer(req0_transfer), .req0_addr(req0_addr), .req0_write(req0_write),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_done(req0_done),
        .req1_transfer(req1_transfer), .req1_addr(req1_addr), .req1_write(req1_write),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_done(req1_done),
        .gnt(gnt), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .err(err)
    );

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] rd_model[2];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input int m, input logic on, input logic [31:0] a,
                             input logic w, input logic [31:0] d);
        if (m == 0) begin
            req0_transfer = on; req0_addr = a; req0_write = w; req0_wdata = d;
        end else begin
            req1_transfer = on; req1_addr = a; req1_write = w; req1_wdata = d;
        end
    endtask

    // One transfer from master m. waits = ACCESS cycles with PREADY low,
    // lat = cycle (request raised in cycle 0) in which done must pulse.
    task automatic xfer(input string tag, input int m, input logic [31:0] addr,
                        input logic wr, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input int lat, input logic exp_err,
                        input logic withdraw);
        sb_t e;
        e.m   = m;
        e.err = exp_err;
        e.rd  = exp_err ? 32'hDEAD_BEEF : (wr ? rd_model[m] : rd);
        rd_model[m] = e.rd;
        sb.push_back(e);
        prdata_drv = rd;
        PREADY     = 1'b0;
        drive_req(m, 1'b1, addr, wr, wd);
        for (int c = 1; c <= lat; c++) begin
            tick();
            PREADY = (c >= 2 + waits);
            if (c == 1) begin
                chk({tag, "_setup_psel"}, PSEL, 1'b1);
                chk({tag, "_setup_pen"}, PENABLE, 1'b0);
                chk({tag, "_gnt"}, gnt, 2'b01 << m);
                chk({tag, "_paddr"}, PADDR, addr);
                chk({tag, "_pwrite"}, PWRITE, wr);
                // Later changes on the request inputs must not reach the bus.
                drive_req(m, !withdraw, 32'h0000_03FC, wr, ~wd);
            end else if (c < lat) begin
                chk({tag, "_access_pen"}, PENABLE, 1'b1);
                chk({tag, "_access_paddr"}, PADDR, addr);
                if (wr) chk({tag, "_pwdata"}, PWDATA, wd);
            end else begin
                chk({tag, "_done_lat"}, (m == 0) ? req0_done : req1_done, 1'b1);
                chk({tag, "_done_psel"}, PSEL, 1'b0);
            end
        end
        drive_req(m, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk({tag, "_idle_gnt"}, gnt, 2'b00);
        chk({tag, "_idle_psel"}, PSEL, 1'b0);
        PREADY = 1'b0;
    endtask

    // Scoreboard monitor and bus protocol checks.
    logic       done_prev = 1'b0;
    logic       psel_prev = 1'b0;
    logic [1:0] gnt_prev  = 2'b00;

    always @(negedge CLK) begin
        if (req0_done === 1'b1 || req1_done === 1'b1) begin
            chk("done_both", req0_done & req1_done, 1'b0);
            chk("done_pulse", done_prev, 1'b0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", {req1_done, req0_done}, 2'b00);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_master", req1_done, e.m[0]);
                chk("sb_rdata", (e.m == 1) ? req1_rdata : req0_rdata, e.rd);
                chk("sb_err", err, e.err);
            end
        end
        if (PSEL === 1'b1 && psel_prev) chk("gnt_stable", gnt, gnt_prev);
        done_prev = req0_done | req1_done;
        psel_prev = PSEL;
        gnt_prev  = gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn = 1'b0; PREADY = 1'b0; use_mem = 1'b0; prdata_drv = 32'h0;
        drive_req(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
        rd_model[0] = 32'h0;
        rd_model[1] = 32'h0;
        tick();
        tick();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_pen", PENABLE, 1'b0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", {req1_done, req0_done}, 2'b00);
        chk("rst_rdata", {req1_rdata, req0_rdata}, 64'h0);
        chk("rst_bus", {PADDR, PWDATA}, 64'h0);
        chk("rst_err", err, 1'b0);
        RESETn = 1'b1;
        tick();

        // Single read, minimum latency.
        xfer("rd0", 0, 32'h100, 1'b0, 32'h0, 32'h1234_5678, 0, 3, 1'b0, 1'b0);
        // Write with three wait states; rdata of master1 untouched.
        xfer("wr1", 1, 32'h200, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 3, 6, 1'b0, 1'b0);
        // Request withdrawn during SETUP still completes.
        xfer("wd0", 0, 32'h104, 1'b0, 32'h0, 32'h0000_4444, 0, 3, 1'b0, 1'b1);
        tick();
        chk("wd0_no_regrant", PSEL, 1'b0);

        // Reset while in ACCESS.
        drive_req(1, 1'b1, 32'h208, 1'b0, 32'h0);
        PREADY = 1'b0;
        tick();
        tick();
        chk("rstmid_pen_before", PENABLE, 1'b1);
        RESETn = 1'b0;
        tick();
        chk("rstmid_psel", PSEL, 1'b0);
        chk("rstmid_pen", PENABLE, 1'b0);
        chk("rstmid_gnt", gnt, 2'b00);
        chk("rstmid_done", {req1_done, req0_done}, 2'b00);
        chk("rstmid_rdata0", req0_rdata, 32'h0);
        RESETn = 1'b1;
        drive_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
        rd_model[0] = 32'h0;
        rd_model[1] = 32'h0;

        // Contention straight out of reset: strict alternation from master0.
        use_mem = 1'b1;
        PREADY  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb_t e;
            e.m   = k % 2;
            e.rd  = (k % 2 == 0) ? 32'h5A00_0180 : 32'h5A00_0300;
            e.err = 1'b0;
            sb.push_back(e);
        end
        drive_req(0, 1'b1, 32'h180, 1'b0, 32'h0);
        drive_req(1, 1'b1, 32'h300, 1'b0, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c % 4 == 1) begin
                chk("cont_gnt", gnt, ((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
                chk("cont_psel", PSEL, 1'b1);
            end
            if (c == 15) begin
                drive_req(0, 1'b0, 32'h0, 1'b0, 32'h0);
                drive_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
            end
        end
        chk("cont_end_gnt", gnt, 2'b00);
        chk("cont_end_psel", PSEL, 1'b0);
        use_mem = 1'b0;
        PREADY  = 1'b0;
        rd_model[0] = 32'h5A00_0180;
        rd_model[1] = 32'h5A00_0300;

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after four ACCESS cycles.
        xfer("tmo", 0, 32'h120, 1'b0, 32'h0, 32'h1111_2222, 100, 6, 1'b1, 1'b0);
`else
        // Long stall completes normally, no abort.
        xfer("stall", 0, 32'h120, 1'b0, 32'h0, 32'h1111_2222, 20, 23, 1'b0, 1'b0);
`endif
        // Normal service afterwards.
        xfer("rd1", 1, 32'h3F0, 1'b0, 32'h0, 32'hCAFE_0001, 1, 4, 1'b0, 1'b0);

        tick();
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
